// File: rtl/pwm_motor_pkg.sv
// Shared types and helpers for the PWM motor-speed controller.
package pwm_motor_pkg;

   // Width of the upstream period counter and of the seconds-remaining field.
   localparam int CNT_W    = 10;
   localparam int REMAIN_W = 3;

   // Motor speed selection; the encoding is visible on o_motor_state.
   typedef enum logic [1:0] {
      MOTOR_OFF  = 2'd0,
      MOTOR_LOW  = 2'd1,
      MOTOR_MID  = 2'd2,
      MOTOR_HIGH = 2'd3
   } motor_state_t;

   // Auto-off timer selection; the encoding is visible on o_timer_sel.
   typedef enum logic [1:0] {
      TSEL_NONE = 2'd0,
      TSEL_3S   = 2'd1,
      TSEL_5S   = 2'd2,
      TSEL_7S   = 2'd3
   } timer_sel_t;

   // Seconds loaded into the countdown for a given timer selection.
   function automatic logic [REMAIN_W-1:0] timer_seconds(input timer_sel_t sel);
      logic [REMAIN_W-1:0] secs;
      case (sel)
         TSEL_3S: secs = 3'd3;
         TSEL_5S: secs = 3'd5;
         TSEL_7S: secs = 3'd7;
         default: secs = 3'd0;
      endcase
      return secs;
   endfunction

   // Mode button order: OFF -> LOW -> MID -> HIGH -> OFF.
   function automatic motor_state_t next_motor_state(input motor_state_t s);
      motor_state_t n;
      case (s)
         MOTOR_OFF: n = MOTOR_LOW;
         MOTOR_LOW: n = MOTOR_MID;
         MOTOR_MID: n = MOTOR_HIGH;
         default:   n = MOTOR_OFF;
      endcase
      return n;
   endfunction

   // Timer button order: none -> 3 s -> 5 s -> 7 s -> none.
   function automatic timer_sel_t next_timer_sel(input timer_sel_t s);
      timer_sel_t n;
      case (s)
         TSEL_NONE: n = TSEL_3S;
         TSEL_3S:   n = TSEL_5S;
         TSEL_5S:   n = TSEL_7S;
         default:   n = TSEL_NONE;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a debounced level button: one press per assertion.
module btn_edge (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press
);

   logic prev;

   // Remember the previous button level so a held button is seen only once.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev <= 1'b0;
      end else begin
         prev <= btn;
      end
   end

   assign press = btn & ~prev;

endmodule

// File: rtl/pwm_motor_ctrl.sv
// PWM motor-speed controller: button-selected speed, period-aligned duty
// updates, and an optional auto-off countdown timer.
module pwm_motor_ctrl
   import pwm_motor_pkg::*;
#(
   parameter int CNT_MAX         = 999,
   parameter int DUTY_LOW        = 250,
   parameter int DUTY_MID        = 500,
   parameter int DUTY_HIGH       = 750,
   parameter int PERIODS_PER_SEC = 100000
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [CNT_W-1:0]    i_counter,
   input  logic                i_btn_mode,
   input  logic                i_btn_timer,
   output logic                o_pwm,
   output logic [1:0]          o_motor_state,
   output logic [1:0]          o_timer_sel,
   output logic [REMAIN_W-1:0] o_remain_sec
);

   // A one-period-per-second configuration still needs a one-bit tick counter.
   localparam int TICK_W = (PERIODS_PER_SEC > 1) ? $clog2(PERIODS_PER_SEC) : 1;

   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CNT_MAX);
   localparam logic [CNT_W-1:0]  DUTY_L     = CNT_W'(DUTY_LOW);
   localparam logic [CNT_W-1:0]  DUTY_M     = CNT_W'(DUTY_MID);
   localparam logic [CNT_W-1:0]  DUTY_H     = CNT_W'(DUTY_HIGH);
   localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(PERIODS_PER_SEC - 1);

   motor_state_t        state;
   timer_sel_t          timer_sel;
   logic [REMAIN_W-1:0] remain_sec;
   logic [TICK_W-1:0]   r_tick;
   logic [CNT_W-1:0]    r_duty;
   logic [CNT_W-1:0]    duty_target;

   logic mode_press;
   logic timer_press;
   logic at_wrap;
   logic timer_running;
   logic expire;

   btn_edge u_mode_edge (
      .clk   (i_clk),
      .reset (i_reset),
      .btn   (i_btn_mode),
      .press (mode_press)
   );

   btn_edge u_timer_edge (
      .clk   (i_clk),
      .reset (i_reset),
      .btn   (i_btn_timer),
      .press (timer_press)
   );

   // Last counter value of the period: duty reload and timer tick point.
   assign at_wrap = (i_counter == CNT_LAST);

   // The countdown only advances with the motor on and a timer selected.
   assign timer_running = (state != MOTOR_OFF) && (timer_sel != TSEL_NONE);

   // Final tick of the last second; overrides any button press this cycle.
   assign expire = timer_running && at_wrap && (r_tick == TICK_LAST) &&
                   (remain_sec == REMAIN_W'(1));

   // Compare value for the current speed selection.
   always_comb begin
      duty_target = '0;
      case (state)
         MOTOR_LOW:  duty_target = DUTY_L;
         MOTOR_MID:  duty_target = DUTY_M;
         MOTOR_HIGH: duty_target = DUTY_H;
         default:    duty_target = '0;
      endcase
   end

   // Speed FSM with timer selection and countdown; entering OFF clears the timer.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state      <= MOTOR_OFF;
         timer_sel  <= TSEL_NONE;
         remain_sec <= '0;
         r_tick     <= '0;
      end else if (expire) begin
         state      <= MOTOR_OFF;
         timer_sel  <= TSEL_NONE;
         remain_sec <= '0;
         r_tick     <= '0;
      end else if (mode_press && (state == MOTOR_HIGH)) begin
         state      <= MOTOR_OFF;
         timer_sel  <= TSEL_NONE;
         remain_sec <= '0;
         r_tick     <= '0;
      end else begin
         if (mode_press) begin
            state <= next_motor_state(state);
         end
         if (timer_press && (state != MOTOR_OFF)) begin
            timer_sel  <= next_timer_sel(timer_sel);
            remain_sec <= timer_seconds(next_timer_sel(timer_sel));
            r_tick     <= '0;
         end else if (timer_running && at_wrap) begin
            if (r_tick == TICK_LAST) begin
               r_tick     <= '0;
               remain_sec <= remain_sec - REMAIN_W'(1);
            end else begin
               r_tick <= r_tick + TICK_W'(1);
            end
         end
      end
   end

   // Reload the duty only at the period boundary so a period is never cut
   // short; expiry at that same boundary makes the following period silent.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_duty <= '0;
      end else if (at_wrap) begin
         r_duty <= expire ? '0 : duty_target;
      end
   end

   // Registered compare: o_pwm lags the counter by one clock.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_pwm <= 1'b0;
      end else begin
         o_pwm <= (i_counter < r_duty);
      end
   end

   assign o_motor_state = state;
   assign o_timer_sel   = timer_sel;
   assign o_remain_sec  = remain_sec;

endmodule

// File: tb/tb_pwm_motor_ctrl.sv
// Self-checking bench for pwm_motor_ctrl with a behavioural reference model.
module tb_pwm_motor_ctrl;

   localparam int CNT_MAX = 999;
   localparam int PPS     = 2;
   localparam int DL      = 250;
   localparam int DM      = 500;
   localparam int DH      = 750;
   localparam logic [9:0] CNT_LAST = 10'd999;

   logic       i_clk = 1'b0;
   logic       i_reset;
   logic [9:0] i_counter;
   logic       i_btn_mode;
   logic       i_btn_timer;
   logic       o_pwm;
   logic [1:0] o_motor_state;
   logic [1:0] o_timer_sel;
   logic [2:0] o_remain_sec;

   int checks = 0;
   int errors = 0;
   logic [10:0] exp_q[$];

   // Reference model state, kept as plain integers.
   int m_state, m_sel, m_remain, m_tick, m_duty, m_pwm;
   bit m_prev_mode, m_prev_timer;
   int duty_tab[4] = '{0, DL, DM, DH};
   int secs_tab[4] = '{0, 3, 5, 7};

   pwm_motor_ctrl #(
      .CNT_MAX         (CNT_MAX),
      .DUTY_LOW        (DL),
      .DUTY_MID        (DM),
      .DUTY_HIGH       (DH),
      .PERIODS_PER_SEC (PPS)
   ) dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_counter     (i_counter),
      .i_btn_mode    (i_btn_mode),
      .i_btn_timer   (i_btn_timer),
      .o_pwm         (o_pwm),
      .o_motor_state (o_motor_state),
      .o_timer_sel   (o_timer_sel),
      .o_remain_sec  (o_remain_sec)
   );

   // Clock and reset
   always #5 i_clk = ~i_clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Model of one clock edge, evaluated from the inputs the DUT is about to sample.
   task automatic model_edge();
      bit mp, tp, wrap, expire;
      int old;
      if (i_reset) begin
         m_state = 0; m_sel = 0; m_remain = 0; m_tick = 0;
         m_duty = 0; m_pwm = 0; m_prev_mode = 0; m_prev_timer = 0;
      end else begin
         mp = i_btn_mode && !m_prev_mode;
         tp = i_btn_timer && !m_prev_timer;
         wrap = (int'(i_counter) == CNT_MAX);
         expire = (m_state != 0) && (m_sel != 0) && wrap && (m_tick == PPS - 1) && (m_remain == 1);
         m_pwm = (int'(i_counter) < m_duty) ? 1 : 0;
         if (wrap) m_duty = expire ? 0 : duty_tab[m_state];
         if (expire || (mp && m_state == 3)) begin
            m_state = 0; m_sel = 0; m_remain = 0; m_tick = 0;
         end else begin
            old = m_state;
            if (mp) m_state = (m_state + 1) % 4;
            if (tp && old != 0) begin
               m_sel = (m_sel + 1) % 4;
               m_remain = secs_tab[m_sel];
               m_tick = 0;
            end else if (old != 0 && m_sel != 0 && wrap) begin
               m_tick++;
               if (m_tick == PPS) begin
                  m_tick = 0;
                  m_remain--;
               end
            end
         end
         m_prev_mode = i_btn_mode;
         m_prev_timer = i_btn_timer;
      end
   endtask

   // Driver: one clock, counter advance, then compare every output to the model.
   task automatic step();
      model_edge();
      @(posedge i_clk);
      #1;
      i_counter = (i_counter == CNT_LAST) ? 10'd0 : 10'(i_counter + 10'd1);
      @(negedge i_clk);
      check_eq("pwm", 32'(o_pwm), 32'(m_pwm));
      check_eq("state", 32'(o_motor_state), 32'(m_state));
      check_eq("timer_sel", 32'(o_timer_sel), 32'(m_sel));
      check_eq("remain", 32'(o_remain_sec), 32'(m_remain));
   endtask

   task automatic press_mode(input int exp_state);
      if (i_counter == CNT_LAST) step();
      i_btn_mode = 1'b1;
      step();
      check_eq("mode_step", 32'(o_motor_state), 32'(exp_state));
      repeat (49) step();
      check_eq("mode_hold", 32'(o_motor_state), 32'(exp_state));
      i_btn_mode = 1'b0;
      repeat (50) step();
   endtask

   // Sum o_pwm over one full period (counter values 0..CNT_MAX), optionally
   // pressing mode while the period runs.
   task automatic measure_high(input int press_at, output int n);
      int guard = 0;
      n = 0;
      while (i_counter != 10'd1 && guard < 2 * (CNT_MAX + 1)) begin
         step();
         guard++;
      end
      for (int i = 0; i <= CNT_MAX; i++) begin
         n += int'(o_pwm);
         if (press_at >= 0 && int'(i_counter) == press_at) i_btn_mode = 1'b1;
         if (press_at >= 0 && int'(i_counter) == press_at + 20) i_btn_mode = 1'b0;
         step();
      end
   endtask

   int n;
   int cnt;
   int dec_at[3];
   int ndec;
   int last_rem;

   initial begin
      i_reset = 1'b1;
      i_counter = 10'd0;
      i_btn_mode = 1'b0;
      i_btn_timer = 1'b0;
      repeat (3) step();
      check_eq("reset_state", 32'(o_motor_state), 32'd0);
      check_eq("reset_pwm", 32'(o_pwm), 32'd0);
      i_reset = 1'b0;
      repeat (20) step();

      // Mid-period reset with motor running and timer selected
      press_mode(1);
      exp_q.push_back(11'(DL));
      measure_high(-1, n);
      check_eq("hi_low", 32'(n), 32'(exp_q.pop_front()));
      i_btn_timer = 1'b1;
      step();
      i_btn_timer = 1'b0;
      check_eq("tsel_pre_reset", 32'(o_timer_sel), 32'd1);
      while (i_counter != 10'd100) step();
      check_eq("pwm_pre_reset", 32'(o_pwm), 32'd1);
      i_reset = 1'b1;
      step();
      check_eq("rst_pwm", 32'(o_pwm), 32'd0);
      check_eq("rst_state", 32'(o_motor_state), 32'd0);
      check_eq("rst_tsel", 32'(o_timer_sel), 32'd0);
      check_eq("rst_remain", 32'(o_remain_sec), 32'd0);
      repeat (2) step();
      i_reset = 1'b0;
      repeat (10) step();

      // Mode cycling
      press_mode(1);
      exp_q.push_back(11'(DL));
      measure_high(-1, n);
      check_eq("cyc_hi_low", 32'(n), 32'(exp_q.pop_front()));
      press_mode(2);
      press_mode(3);
      press_mode(0);
      exp_q.push_back(11'd0);
      measure_high(-1, n);
      check_eq("cyc_hi_off", 32'(n), 32'(exp_q.pop_front()));

      // Mid-period change MID -> HIGH
      press_mode(1);
      press_mode(2);
      exp_q.push_back(11'(DM));
      measure_high(-1, n);
      check_eq("mid_full", 32'(n), 32'(exp_q.pop_front()));
      exp_q.push_back(11'(DM));
      measure_high(100, n);
      check_eq("mid_change_cur", 32'(n), 32'(exp_q.pop_front()));
      exp_q.push_back(11'(DH));
      measure_high(-1, n);
      check_eq("mid_change_next", 32'(n), 32'(exp_q.pop_front()));
      press_mode(0);

      // Timer press ignored while OFF
      i_btn_timer = 1'b1;
      step();
      check_eq("timer_off_ignored", 32'(o_timer_sel), 32'd0);
      i_btn_timer = 1'b0;
      repeat (5) step();

      // Timer expiry: LOW, 3 s, press aligned to counter 0
      press_mode(1);
      while (i_counter != 10'd0) step();
      i_btn_timer = 1'b1;
      step();
      check_eq("timer_sel_3s", 32'(o_timer_sel), 32'd1);
      check_eq("timer_remain_3", 32'(o_remain_sec), 32'd3);
      i_btn_timer = 1'b0;
      cnt = 0;
      ndec = 0;
      last_rem = 3;
      while (o_motor_state != 2'd0 && cnt < 8000) begin
         step();
         cnt++;
         if (int'(o_remain_sec) != last_rem) begin
            if (ndec < 3) dec_at[ndec] = cnt;
            ndec++;
            last_rem = int'(o_remain_sec);
         end
      end
      check_eq("expiry_within_budget", 32'(cnt < 8000), 32'd1);
      check_eq("decrements", 32'(ndec), 32'd3);
      check_eq("dec1_at", 32'(dec_at[0]), 32'd1999);
      check_eq("dec_spacing", 32'(dec_at[1] - dec_at[0]), 32'd2000);
      check_eq("expiry_at", 32'(dec_at[2]), 32'd5999);
      check_eq("expiry_tsel", 32'(o_timer_sel), 32'd0);
      exp_q.push_back(11'd0);
      measure_high(-1, n);
      check_eq("expiry_pwm_off", 32'(n), 32'(exp_q.pop_front()));

      // Collision: mode press on the expiry cycle
      press_mode(1);
      i_btn_timer = 1'b1;
      step();
      i_btn_timer = 1'b0;
      cnt = 0;
      while (!(i_counter == CNT_LAST && m_remain == 1 && m_tick == PPS - 1) && cnt < 8000) begin
         step();
         cnt++;
      end
      check_eq("collision_reached", 32'(cnt < 8000), 32'd1);
      i_btn_mode = 1'b1;
      step();
      check_eq("collision_state", 32'(o_motor_state), 32'd0);
      check_eq("collision_tsel", 32'(o_timer_sel), 32'd0);
      repeat (10) step();
      i_btn_mode = 1'b0;
      step();
      check_eq("collision_stays_off", 32'(o_motor_state), 32'd0);

      // Randomized phase; buttons never rise on the wrap cycle
      repeat (20000) begin
         if ($urandom_range(0, 149) == 0 && (i_counter != CNT_LAST || i_btn_mode))
            i_btn_mode = ~i_btn_mode;
         if ($urandom_range(0, 149) == 0 && (i_counter != CNT_LAST || i_btn_timer))
            i_btn_timer = ~i_btn_timer;
         i_reset = ($urandom_range(0, 3999) == 0);
         step();
      end
      i_reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_motor_ctrl.md
# pwm_motor_ctrl

PWM motor-speed controller that consumes the free-running 10-bit period counter (0..CNT_MAX, wraps to 0) produced by the timebase counter stage. A button-driven state machine selects motor speed OFF/LOW/MID/HIGH. The selected duty is applied glitch-free at period boundaries, and o_pwm is produced by comparing the counter against the duty. An optional auto-off timer (3/5/7 s) returns the motor to OFF on expiry.

## Interface

Parameters:
- CNT_MAX, 999: last counter value of one PWM period; matches the upstream counter wrap.
- DUTY_LOW, 250: compare value for LOW.
- DUTY_MID, 500: compare value for MID.
- DUTY_HIGH, 750: compare value for HIGH.
- PERIODS_PER_SEC, 100000: PWM periods per second; 100 MHz / 1000.

Ports:
- i_clk, input, 1: system clock; same clock as the counter stage.
- i_reset, input, 1: synchronous, active-high reset.
- i_counter, input, 10: period counter from the upstream stage.
- i_btn_mode, input, 1: debounced mode button, level.
- i_btn_timer, input, 1: debounced timer button, level.
- o_pwm, output, 1: motor PWM, registered.
- o_motor_state, output, 2: 0 = OFF, 1 = LOW, 2 = MID, 3 = HIGH.
- o_timer_sel, output, 2: 0 = none, 1 = 3 s, 2 = 5 s, 3 = 7 s.
- o_remain_sec, output, 3: seconds left on the timer; 0 when no timer is selected.

## Operation

- **Edge detection:** each button is registered into a previous-value flop. Press = i_btn & ~prev. A held button gives exactly one press.
- **Mode FSM:** a mode press advances OFF→LOW→MID→HIGH→OFF.
  - Entering OFF by any cause clears o_timer_sel and o_remain_sec to 0.
- **Duty register r_duty:**
  - Target: OFF = 0, LOW = DUTY_LOW, MID = DUTY_MID, HIGH = DUTY_HIGH.
  - Loaded only on a cycle where i_counter == CNT_MAX. A state change mid-period never alters the current period.
- **PWM output:** o_pwm <= (i_counter < r_duty).
  - Duty 0 gives constant low.
  - Duty values above CNT_MAX are illegal parameters.
- **Timer press:**
  - Ignored while the state is OFF.
  - Otherwise advances o_timer_sel 0→1→2→3→0.
  - Loads o_remain_sec with 3/5/7, or 0 when selection 0.
  - Clears the tick counter r_tick.
- **Timer countdown:** runs while the state is not OFF and o_timer_sel != 0.
  - On each i_counter == CNT_MAX, r_tick increments.
  - When r_tick == PERIODS_PER_SEC-1, r_tick wraps to 0 and o_remain_sec decrements.
  - A decrement from 1 to 0 is expiry: state → OFF and o_timer_sel → 0 on the same edge.
- **Simultaneous events:**
  - Expiry and mode press in the same cycle: expiry wins; state = OFF and the press is discarded.
  - Timer press and expiry in the same cycle: expiry wins.
  - Mode press HIGH→OFF with a timer active: timer cleared.
  - Mode press between non-OFF states: timer keeps running.
- **Reset values:** o_pwm 0, o_motor_state OFF, o_timer_sel 0, o_remain_sec 0, r_duty 0, r_tick 0, both prev-button flops 0.
  - A reset mid-period forces o_pwm low on the next edge.

## Timing

- Button rising at cycle N → o_motor_state updated after the edge ending cycle N (1-cycle latency).
- A new duty takes effect in the first full period following the state change. r_duty updates on the edge where i_counter == CNT_MAX, so it is valid when i_counter == 0.
- o_pwm lags i_counter by exactly 1 clock. High-time per period = r_duty clocks, period = CNT_MAX+1 clocks.
- Expiry → o_motor_state = OFF on the same edge. o_pwm remains active for the rest of the current period, then is 0 from the next period.
- r_tick width = clog2(PERIODS_PER_SEC).

## Structure

- Package pwm_motor_pkg:
  - motor state enum (OFF/LOW/MID/HIGH);
  - timer-select encoding;
  - function timer_sel → seconds (0/3/5/7).
- Sub-module btn_edge: registered rising-edge detector with synchronous reset, instantiated twice.
- Everything else is in one module.

## Test plan

Bench uses CNT_MAX = 999 and PERIODS_PER_SEC = 2.

- **Reset:** assert i_reset 3 cycles mid-period → o_pwm = 0, state 0, o_timer_sel 0, o_remain_sec 0 on the edge after the first reset cycle.
- **Mode cycling:** 4 mode presses held 50 cycles each → states 1, 2, 3, 0, each changing one clock after the press. After the LOW period boundary, o_pwm high for 250 of 1000 clocks. Holding a button advances only once.
- **Mid-period change:** MID, press at i_counter = 100 → current period still 500 clocks high; next period 750 clocks high.
- **Timer expiry:** LOW, one timer press → o_timer_sel 1, o_remain_sec 3. o_remain_sec decrements every 2000 clocks. At 6000 clocks state → 0 and o_timer_sel → 0, and o_pwm is 0 from the next period.
- **Timer ignored when OFF:** timer press in the OFF state → o_timer_sel stays 0.
- **Collision:** mode press on the same cycle as expiry → state 0, not the next mode.
